// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Button conditioning, mode FSM and timebase prescaler for the stopwatch
// Revision : 1.0
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int DB_CYC  = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic       o_run,
  output logic       o_tick,
  output logic       o_clr,
  output logic       o_hold,
  output logic [1:0] o_state,
  output logic       led
);

  localparam int c_DIV = CLK_HZ / TICK_HZ;
  localparam int c_PW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_DW  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(c_DIV - 1);
  localparam logic [c_DW-1:0] c_DB_MAX  = c_DW'(DB_CYC - 1);

  localparam logic [1:0] c_IDLE  = 2'b00;
  localparam logic [1:0] c_RUN   = 2'b01;
  localparam logic [1:0] c_PAUSE = 2'b10;
  localparam logic [1:0] c_LAP   = 2'b11;

  logic [2:0] w_btn;
  logic [2:0] w_press;

  assign w_btn = {btn_lap, btn_clr, btn_run};

  // Per button: 2-flop synchronizer, counting debounce, rising-edge detect
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic            r_s1;
    logic            r_s2;
    logic            r_db;
    logic            r_db_q;
    logic [c_DW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_db   <= 1'b0;
        r_db_q <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_s1   <= w_btn[gi];
        r_s2   <= r_s1;
        r_db_q <= r_db;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_MAX) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_DW'(1);
        end
      end
    end

    assign w_press[gi] = r_db & ~r_db_q;
  end

  // Priority run > clr > lap; losing pulses are dropped
  logic w_go_run;
  logic w_go_clr;
  logic w_go_lap;

  assign w_go_run = w_press[0];
  assign w_go_clr = w_press[1] & ~w_press[0];
  assign w_go_lap = w_press[2] & ~w_press[1] & ~w_press[0];

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic            r_run;
  logic            r_tick;
  logic            r_clr;
  logic            r_hold;
  logic [c_PW-1:0] r_pre;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_go_run) w_next = c_RUN;
      end
      c_RUN: begin
        if (w_go_run)      w_next = c_PAUSE;
        else if (w_go_lap) w_next = c_LAP;
      end
      c_LAP: begin
        if (w_go_run)      w_next = c_PAUSE;
        else if (w_go_lap) w_next = c_RUN;
      end
      c_PAUSE: begin
        if (w_go_run)      w_next = c_RUN;
        else if (w_go_clr) w_next = c_IDLE;
      end
      default: w_next = c_IDLE;
    endcase
  end

  logic            w_run_d;
  logic            w_hold_d;
  logic            w_clr_d;
  logic            w_tick_d;
  logic [c_PW-1:0] w_pre_d;

  // Outputs decode the next state so they move on the same edge as r_state
  always_comb begin
    w_run_d  = (w_next == c_RUN) || (w_next == c_LAP);
    w_hold_d = (w_next == c_LAP);
    w_clr_d  = w_go_clr && ((r_state == c_IDLE) || (r_state == c_PAUSE));
    w_tick_d = 1'b0;
    w_pre_d  = r_pre;
    if (w_clr_d) begin
      w_pre_d = '0;
    end else if (w_run_d) begin
      if (r_pre == c_PRE_MAX) begin
        w_pre_d  = '0;
        w_tick_d = 1'b1;
      end else begin
        w_pre_d = r_pre + c_PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run  <= 1'b0;
      r_tick <= 1'b0;
      r_clr  <= 1'b0;
      r_hold <= 1'b0;
      r_pre  <= '0;
    end else begin
      r_run  <= w_run_d;
      r_tick <= w_tick_d;
      r_clr  <= w_clr_d;
      r_hold <= w_hold_d;
      r_pre  <= w_pre_d;
    end
  end

  assign o_run   = r_run;
  assign o_tick  = r_tick;
  assign o_clr   = r_clr;
  assign o_hold  = r_hold;
  assign o_state = r_state;
  assign led     = r_run;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed plus random stimulus against a behavioural stopwatch model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DB_CYC  = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_lap = 1'b0;
  logic       o_run;
  logic       o_tick;
  logic       o_clr;
  logic       o_hold;
  logic [1:0] o_state;
  logic       led;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DB_CYC (DB_CYC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_run(btn_run),
    .btn_clr(btn_clr),
    .btn_lap(btn_lap),
    .o_run  (o_run),
    .o_tick (o_tick),
    .o_clr  (o_clr),
    .o_hold (o_hold),
    .o_state(o_state),
    .led    (led)
  );

  // Model: raw sample history per button, debounced level, pending press,
  // mode code (spec encoding) and count of active edges since last clear.
  logic [15:0] m_hist  [3];
  logic        m_db    [3];
  logic        m_press [3];
  int          m_state;
  int          m_n;
  logic        e_run, e_tick, e_clr, e_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_hist[b]  = '0;
      m_db[b]    = 1'b0;
      m_press[b] = 1'b0;
    end
    m_state = 0;
    m_n     = 0;
    e_run   = 1'b0;
    e_tick  = 1'b0;
    e_clr   = 1'b0;
    e_hold  = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0] raw;
    logic       go_run, go_clr, go_lap, flip;
    int         nxt;
    raw    = {btn_lap, btn_clr, btn_run};
    go_run = m_press[0];
    go_clr = m_press[1] && !go_run;
    go_lap = m_press[2] && !go_run && !go_clr;
    nxt    = m_state;
    e_clr  = 1'b0;
    case (m_state)
      0: if (go_run) nxt = 1; else if (go_clr) e_clr = 1'b1;
      1: if (go_run) nxt = 2; else if (go_lap) nxt = 3;
      3: if (go_run) nxt = 2; else if (go_lap) nxt = 1;
      default: if (go_run) nxt = 1; else if (go_clr) begin nxt = 0; e_clr = 1'b1; end
    endcase
    m_state = nxt;
    e_run   = (nxt == 1) || (nxt == 3);
    e_hold  = (nxt == 3);
    e_tick  = 1'b0;
    if (e_clr) begin
      m_n = 0;
    end else if (e_run) begin
      m_n++;
      e_tick = (m_n % DIV) == 0;
    end
    // Debounced level flips once DB_CYC consecutive synchronized samples disagree
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][14:0], raw[b]};
      flip = 1'b1;
      for (int j = 2; j <= DB_CYC + 1; j++)
        if (m_hist[b][j] == m_db[b]) flip = 1'b0;
      m_press[b] = flip && !m_db[b];
      if (flip) m_db[b] = ~m_db[b];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_no++;
    if (reset) model_reset();
    else       model_edge();
    #1;
    check("state", 32'(o_state), 32'(m_state));
    check("run",   32'(o_run),   32'(e_run));
    check("tick",  32'(o_tick),  32'(e_tick));
    check("clr",   32'(o_clr),   32'(e_clr));
    check("hold",  32'(o_hold),  32'(e_hold));
    check("led",   32'(led),     32'(e_run));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_btns(input logic [2:0] m);
    btn_run = m[0];
    btn_clr = m[1];
    btn_lap = m[2];
  endtask

  // Hold buttons until the press has acted, then release and let it debounce
  task automatic press(input logic [2:0] m);
    set_btns(m);
    step(DB_CYC + 3);
    set_btns(3'b000);
    step(DB_CYC + 4);
  endtask

  int   dur [3];
  logic lvl [3];

  initial begin
    model_reset();
    step(2);
    check("rst_state", 32'(o_state), 32'd0);
    reset = 1'b0;
    edge_no = 0;

    // Run press sampled from edge 10: RUN at edge 16, first tick after edge 25
    step(9);
    btn_run = 1'b1;
    step(6);
    check("s1_idle_e15", 32'(o_state), 32'd0);
    step(1);
    check("s1_run_e16", 32'(o_state), 32'd1);
    check("s1_orun_e16", 32'(o_run), 32'd1);
    step(8);
    check("s1_notick_e24", 32'(o_tick), 32'd0);
    step(1);
    check("s1_tick_e25", 32'(o_tick), 32'd1);
    step(4);
    btn_run = 1'b0;
    step(12);

    // Short glitch must not toggle the mode
    btn_run = 1'b1; step(1);
    btn_run = 1'b0; step(1);
    btn_run = 1'b1; step(1);
    btn_run = 1'b0; step(10);
    check("s2_glitch", 32'(o_state), 32'd1);

    press(3'b100);
    check("s3_lap", 32'(o_state), 32'd3);
    check("s3_hold", 32'(o_hold), 32'd1);
    press(3'b100);
    check("s3_unlap", 32'(o_state), 32'd1);

    press(3'b001);
    check("s4_pause", 32'(o_state), 32'd2);
    press(3'b001);
    check("s4_resume", 32'(o_state), 32'd1);

    press(3'b001);
    press(3'b011);
    check("s5_run_wins", 32'(o_state), 32'd1);
    press(3'b001);
    set_btns(3'b010);
    step(DB_CYC + 3);
    check("s5_clr_state", 32'(o_state), 32'd0);
    check("s5_clr_pulse", 32'(o_clr), 32'd1);
    step(1);
    check("s5_clr_end", 32'(o_clr), 32'd0);
    set_btns(3'b000);
    step(DB_CYC + 4);

    // Asynchronous reset in LAP with run held through the reset
    press(3'b001);
    press(3'b100);
    check("s6_in_lap", 32'(o_state), 32'd3);
    btn_run = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_state", 32'(o_state), 32'd0);
    check("s6_async_run", 32'(o_run), 32'd0);
    check("s6_async_hold", 32'(o_hold), 32'd0);
    cycle();
    reset = 1'b0;
    step(DB_CYC + 3);
    check("s6_held_press", 32'(o_state), 32'd1);
    btn_run = 1'b0;
    step(DB_CYC + 4);

    // Random button activity with occasional glitches and resets
    for (int b = 0; b < 3; b++) begin
      dur[b] = 0;
      lvl[b] = 1'b0;
    end
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (dur[b] == 0) begin
          if ($urandom_range(3) == 0) dur[b] = $urandom_range(1, 3);
          else                        dur[b] = $urandom_range(5, 40);
          lvl[b] = ($urandom_range(2) == 0);
        end
        dur[b]--;
      end
      btn_run = lvl[0];
      btn_clr = lvl[1];
      btn_lap = lvl[2];
      reset   = ($urandom_range(599) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
